sc_sng_bank: RTL and testbench

Bank of N stochastic number generators that turns N binary operands into N parallel unipolar bitstreams for the APC neuron's `din` and `weight` inputs. One operand vector is accepted through a valid/ready handshake. Exactly one full LFSR period of stream bits is then emitted, with a done pulse at the end. For every channel, the ones-count over the stream equals the operand exactly.

---
 rtl/sc_sng_bank.sv | 112 +++++++++++
 tb/tb_sc_sng_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_sng_bank.sv
// rtl/sc_sng_bank.sv - bank of N stochastic number generators sharing one Galois LFSR
// Optional feature macro: SC_SNG_RESEED_EN (reload LFSR with SEED on every accept)
module sc_sng_bank #(
   parameter int             K    = 3,
   parameter int             N    = 2**K,
   parameter int             W    = 8,
   parameter logic [W-1:0]   TAPS = 8'hB8,
   parameter logic [W-1:0]   SEED = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [N*W-1:0]   values,
   output logic [N-1:0]     stream,
   output logic             stream_valid,
   output logic             done
);

   localparam logic [W-1:0] SEED_L = (SEED == '0) ? W'(1) : SEED;
   localparam logic [W-1:0] LAST   = {{(W-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {S_IDLE, S_LATCH, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [N*W-1:0]   vals_q, vals_d;
   logic [W-1:0]     lfsr_q, lfsr_d;
   logic [W-1:0]     cnt_q, cnt_d;
   logic [N-1:0]     stream_q, stream_d;
   logic             stream_valid_q, stream_valid_d;
   logic             done_q, done_d;
   logic             accept;

   function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
      return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
   endfunction

   function automatic logic [W-1:0] rotl(input logic [W-1:0] s, input int r);
      logic [2*W-1:0] d;
      d = {s, s} << r;
      return d[2*W-1:W];
   endfunction

   assign accept = load_valid && (state_q == S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         vals_q         <= '0;
         lfsr_q         <= SEED_L;
         cnt_q          <= '0;
         stream_q       <= '0;
         stream_valid_q <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         vals_q         <= vals_d;
         lfsr_q         <= lfsr_d;
         cnt_q          <= cnt_d;
         stream_q       <= stream_d;
         stream_valid_q <= stream_valid_d;
         done_q         <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vals_d  = vals_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_LATCH;
               cnt_d   = '0;
               vals_d  = values;
            end
         end
         S_LATCH: state_d = S_RUN;
         S_RUN: begin
            if (cnt_q == LAST) state_d = S_IDLE;
            else               cnt_d   = cnt_q + W'(1);
         end
         default: state_d = S_IDLE;
      endcase
`ifdef SC_SNG_RESEED_EN
      // Advance only on edges that emit a bit, so bit 0 always uses SEED
      if (accept)                 lfsr_d = SEED_L;
      else if (state_d == S_RUN)  lfsr_d = lfsr_step(lfsr_q);
      else                        lfsr_d = lfsr_q;
`else
      lfsr_d = lfsr_step(lfsr_q);
`endif
   end

   // Bits are registered on the edge entering each RUN cycle, from the current LFSR word
   always_comb begin
      logic [W-1:0] r;
      stream_d       = '0;
      stream_valid_d = (state_d == S_RUN);
      done_d         = (state_d == S_RUN) && (cnt_d == LAST);
      for (int i = 0; i < N; i++) begin
         r = rotl(lfsr_q, i % W) - W'(1);
         if (state_d == S_RUN) stream_d[i] = (vals_q[i*W +: W] > r);
      end
   end

   assign load_ready   = (state_q == S_IDLE);
   assign stream       = stream_q;
   assign stream_valid = stream_valid_q;
   assign done         = done_q;

endmodule

// File: tb/tb_sc_sng_bank.sv
// tb/tb_sc_sng_bank.sv - directed testbench for sc_sng_bank
module tb_sc_sng_bank;
   localparam int K = 3, N = 8, W = 8, LEN = 255;

   logic           clk = 1'b0;
   logic           reset;
   logic           load_valid;
   logic           load_ready;
   logic [N*W-1:0] values;
   logic [N-1:0]   stream;
   logic           stream_valid;
   logic           done;

   sc_sng_bank #(.K(K), .N(N), .W(W), .TAPS(8'hB8), .SEED(8'd1)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .values(values), .stream(stream), .stream_valid(stream_valid), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int vin[N];
   int ones[N];
   int valid_n, first_valid, last_valid, done_n, done_at, ready_at, bad_idle, ready_k1;
   logic [N-1:0] sbuf[LEN];
   logic [N-1:0] sbuf_a[LEN];

   function automatic logic [N*W-1:0] pack_vin();
      logic [N*W-1:0] p;
      for (int i = 0; i < N; i++) p[i*W +: W] = vin[i][W-1:0];
      return p;
   endfunction

   task automatic accept(input logic [N*W-1:0] v);
      @(negedge clk);
      values = v;
      load_valid = 1'b1;
      @(posedge clk);
   endtask

   task automatic collect(input bit hold, input int change_at, input logic [N*W-1:0] alt);
      for (int i = 0; i < N; i++) ones[i] = 0;
      valid_n = 0; first_valid = -1; last_valid = -1; done_n = 0; done_at = -1;
      ready_at = -1; bad_idle = 0; ready_k1 = -1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (k == 1) begin
            load_valid = hold;
            ready_k1 = int'(load_ready);
         end
         if (k == change_at) values = alt;
         if (stream_valid) begin
            valid_n++;
            if (first_valid < 0) first_valid = k;
            last_valid = k;
            if (valid_n <= LEN) sbuf[valid_n-1] = stream;
            for (int i = 0; i < N; i++) ones[i] += int'(stream[i]);
         end else if (stream !== '0) bad_idle++;
         if (done) begin done_n++; done_at = k; end
         if (k >= 2 && load_ready) begin ready_at = k; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; load_valid = 1'b0; values = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready cyc=%0d got=%b exp=1", c, load_ready); end
         checks++;
         if (stream !== '0) begin failures++; $display("FAIL reset_stream cyc=%0d got=%h exp=0", c, stream); end
         checks++;
         if (stream_valid !== 1'b0) begin failures++; $display("FAIL reset_stream_valid cyc=%0d got=%b exp=0", c, stream_valid); end
         checks++;
         if (done !== 1'b0) begin failures++; $display("FAIL reset_done cyc=%0d got=%b exp=0", c, done); end
      end
   endtask

   task automatic test_counts_timing();
      vin = '{0, 1, 64, 127, 128, 200, 254, 255};
      accept(pack_vin());
      collect(1'b0, 0, '0);
      checks++;
      if (ready_k1 !== 0) begin failures++; $display("FAIL latch_ready got=%0d exp=0", ready_k1); end
      checks++;
      if (first_valid !== 2) begin failures++; $display("FAIL first_valid got=%0d exp=2", first_valid); end
      checks++;
      if (last_valid !== 256) begin failures++; $display("FAIL last_valid got=%0d exp=256", last_valid); end
      checks++;
      if (valid_n !== LEN) begin failures++; $display("FAIL valid_count got=%0d exp=%0d", valid_n, LEN); end
      checks++;
      if (done_n !== 1 || done_at !== 256) begin failures++; $display("FAIL done_pulse got_n=%0d at=%0d exp_n=1 at=256", done_n, done_at); end
      checks++;
      if (ready_at !== 257) begin failures++; $display("FAIL ready_return got=%0d exp=257", ready_at); end
      checks++;
      if (bad_idle !== 0) begin failures++; $display("FAIL stream_when_invalid got=%0d exp=0", bad_idle); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (ones[i] !== vin[i]) begin failures++; $display("FAIL count_ch%0d got=%0d exp=%0d", i, ones[i], vin[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int exp_b[N];
      logic [N*W-1:0] vb;
      vin = '{10, 20, 30, 40, 50, 60, 70, 80};
      accept(pack_vin());
      collect(1'b1, 0, '0);
      checks++;
      if (ready_at !== 257) begin failures++; $display("FAIL b2b_ready_first got=%0d exp=257", ready_at); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (ones[i] !== vin[i]) begin failures++; $display("FAIL b2b_a_count_ch%0d got=%0d exp=%0d", i, ones[i], vin[i]); end
      end
      vin = '{250, 5, 100, 33, 0, 255, 17, 128};
      for (int i = 0; i < N; i++) exp_b[i] = vin[i];
      vb = pack_vin();
      values = vb;
      @(posedge clk);
      vin = '{1, 2, 3, 4, 5, 6, 7, 8};
      collect(1'b0, 100, pack_vin());
      checks++;
      if (ready_k1 !== 0 || first_valid !== 2) begin failures++; $display("FAIL b2b_spacing got_ready=%0d first=%0d exp_ready=0 first=2", ready_k1, first_valid); end
      checks++;
      if (done_at !== 256 || ready_at !== 257) begin failures++; $display("FAIL b2b_second_end got_done=%0d ready=%0d exp=256/257", done_at, ready_at); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (ones[i] !== exp_b[i]) begin failures++; $display("FAIL b2b_b_count_ch%0d got=%0d exp=%0d", i, ones[i], exp_b[i]); end
      end
   endtask

   task automatic test_reset_mid_run();
      int dn;
      int sv;
      vin = '{200, 200, 200, 200, 200, 200, 200, 200};
      accept(pack_vin());
      sv = 0;
      for (int k = 1; k <= 102; k++) begin
         @(negedge clk);
         if (k == 1) load_valid = 1'b0;
         if (k == 102) sv = int'(stream_valid);
      end
      checks++;
      if (sv !== 1) begin failures++; $display("FAIL midrun_in_run got=%0d exp=1", sv); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (load_ready !== 1'b1 || stream !== '0 || stream_valid !== 1'b0 || done !== 1'b0)
         begin failures++; $display("FAIL midrun_reset_outputs got=%b/%h/%b/%b exp=1/00/0/0", load_ready, stream, stream_valid, done); end
      dn = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (done || stream_valid || !load_ready) dn++;
      end
      checks++;
      if (dn !== 0) begin failures++; $display("FAIL midrun_no_done got=%0d exp=0", dn); end
      vin = '{3, 77, 128, 254, 255, 0, 99, 160};
      accept(pack_vin());
      collect(1'b0, 0, '0);
      checks++;
      if (valid_n !== LEN || done_n !== 1) begin failures++; $display("FAIL midrun_after got_valid=%0d done=%0d exp=255/1", valid_n, done_n); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (ones[i] !== vin[i]) begin failures++; $display("FAIL midrun_count_ch%0d got=%0d exp=%0d", i, ones[i], vin[i]); end
      end
   endtask

   task automatic test_reseed();
      int diff;
      vin = '{90, 90, 90, 90, 90, 90, 90, 90};
      accept(pack_vin());
      collect(1'b0, 0, '0);
      for (int j = 0; j < LEN; j++) sbuf_a[j] = sbuf[j];
      for (int i = 0; i < N; i++) begin
         checks++;
         if (ones[i] !== 90) begin failures++; $display("FAIL reseed_a_count_ch%0d got=%0d exp=90", i, ones[i]); end
      end
      accept(pack_vin());
      collect(1'b0, 0, '0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (ones[i] !== 90) begin failures++; $display("FAIL reseed_b_count_ch%0d got=%0d exp=90", i, ones[i]); end
      end
      diff = 0;
      for (int j = 0; j < LEN; j++) if (sbuf[j] !== sbuf_a[j]) diff++;
`ifdef SC_SNG_RESEED_EN
      checks++;
      if (diff !== 0) begin failures++; $display("FAIL reseed_identical got_diff=%0d exp=0", diff); end
      checks++;
      if (sbuf_a[0][0] !== 1'b1) begin failures++; $display("FAIL reseed_first_bit got=%b exp=1", sbuf_a[0][0]); end
`else
      checks++;
      if (diff == 0) begin failures++; $display("FAIL freerun_order_differs got_diff=%0d exp=nonzero", diff); end
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_counts_timing();
      test_back_to_back();
      test_reset_mid_run();
      test_reseed();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
